// File: rtl/aximm_test0_mul_pipe_vr.sv
// aximm_test0_mul_pipe_vr: pipelined valid/ready multiplier with per-beat sign mode, optional accumulate and sideband tag
module aximm_test0_mul_pipe_vr #(
  parameter int DIN0_WIDTH = 32,
  parameter int DIN1_WIDTH = 28,
  parameter int DOUT_WIDTH = 60,
  parameter int NUM_STAGE  = 2,
  parameter int ACC_EN     = 0,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  in_signed,
  input  logic                  in_acc,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic [TAG_WIDTH-1:0]  out_tag
);
  // Operands are extended (or truncated) straight to DOUT_WIDTH: the product modulo
  // 2^DOUT_WIDTH of the extended operands equals the full signed product truncated,
  // or sign-extended when DOUT_WIDTH exceeds the full product width.
  logic [DOUT_WIDTH-1:0] a_w, b_w, prod, acc, fin;
  logic [NUM_STAGE-1:0] v, a, src_v, src_a;
  logic [DOUT_WIDTH-1:0] d [NUM_STAGE];
  logic [DOUT_WIDTH-1:0] src_d [NUM_STAGE];
  logic [TAG_WIDTH-1:0] t [NUM_STAGE];
  logic [TAG_WIDTH-1:0] src_t [NUM_STAGE];
  logic adv;
  logic unused_tail;

  if (DOUT_WIDTH > DIN0_WIDTH) begin : g_a_ext
    assign a_w = {{(DOUT_WIDTH-DIN0_WIDTH){in_signed & din0[DIN0_WIDTH-1]}}, din0};
  end else begin : g_a_trunc
    logic unused_a;
    assign a_w = din0[DOUT_WIDTH-1:0];
    assign unused_a = ^din0[DIN0_WIDTH-1:DOUT_WIDTH-1];
  end

  if (DOUT_WIDTH > DIN1_WIDTH) begin : g_b_ext
    assign b_w = {{(DOUT_WIDTH-DIN1_WIDTH){in_signed & din1[DIN1_WIDTH-1]}}, din1};
  end else begin : g_b_trunc
    logic unused_b;
    assign b_w = din1[DOUT_WIDTH-1:0];
    assign unused_b = ^din1[DIN1_WIDTH-1:DOUT_WIDTH-1];
  end

  assign prod        = a_w * b_w;
  assign adv         = !v[NUM_STAGE-1] || out_ready;
  assign in_ready    = adv && reset_n;
  assign out_valid   = v[NUM_STAGE-1];
  assign dout        = d[NUM_STAGE-1];
  assign out_tag     = t[NUM_STAGE-1];
  assign unused_tail = a[NUM_STAGE-1];

  // Source of each stage on advance: stage 0 takes the new beat, later stages their predecessor
  always_comb begin
    src_v[0] = in_valid;
    src_a[0] = in_acc;
    src_d[0] = prod;
    src_t[0] = in_tag;
    for (int i = 1; i < NUM_STAGE; i++) begin
      src_v[i] = v[i-1];
      src_a[i] = a[i-1];
      src_d[i] = d[i-1];
      src_t[i] = t[i-1];
    end
    fin = (ACC_EN != 0 && src_a[NUM_STAGE-1]) ? acc + src_d[NUM_STAGE-1] : src_d[NUM_STAGE-1];
  end

  // Pipeline shift register; bubbles move with the beats and everything holds on a stall
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v <= '0;
      a <= '0;
      for (int i = 0; i < NUM_STAGE; i++) begin
        d[i] <= '0;
        t[i] <= '0;
      end
    end else if (adv) begin
      v <= src_v;
      a <= src_a;
      for (int i = 0; i < NUM_STAGE - 1; i++) begin
        d[i] <= src_d[i];
        t[i] <= src_t[i];
      end
      d[NUM_STAGE-1] <= fin;
      t[NUM_STAGE-1] <= src_t[NUM_STAGE-1];
    end
  end

  if (ACC_EN != 0) begin : g_acc
    // Accumulator follows each valid beat loaded into the final stage
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) acc <= '0;
      else if (adv && src_v[NUM_STAGE-1]) acc <= fin;
    end
  end else begin : g_noacc
    assign acc = '0;
  end
endmodule

// File: tb/tb_aximm_test0_mul_pipe_vr.sv
// tb_aximm_test0_mul_pipe_vr: scoreboard bench for the main MAC instance plus a stage/width sweep
module tb_aximm_test0_mul_pipe_vr;
  localparam logic [63:0] M60 = (64'd1 << 60) - 1;

  typedef struct {
    int          k;
    logic [63:0] d;
    logic [3:0]  t;
    int          c;
    bit          lat;
  } ent_t;

  logic clk = 0;
  logic reset_n, in_valid, out_ready, in_signed, in_acc;
  logic [31:0] din0;
  logic [27:0] din1;
  logic [3:0] in_tag;
  logic ov [4];
  logic ir [4];
  logic [3:0] ot [4];
  logic [63:0] od [4];
  logic [59:0] d0;
  logic [15:0] d1;
  logic [63:0] d2, d3;
  int ns [4] = '{2, 1, 4, 8};
  int dw [4] = '{60, 16, 64, 64};
  ent_t sb [$];
  int ncmp = 0, nerr = 0, cycle = 0;
  bit free, prev_stall;
  logic m_acc;
  logic [63:0] macc, prev_d;
  logic [3:0] prev_t, tg;

  always #5 clk = ~clk;

  aximm_test0_mul_pipe_vr #(.ACC_EN(1)) u0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[0]), .din0(din0), .din1(din1),
    .in_signed(in_signed), .in_acc(in_acc), .in_tag(in_tag), .out_valid(ov[0]), .out_ready(out_ready),
    .dout(d0), .out_tag(ot[0]));
  aximm_test0_mul_pipe_vr #(.NUM_STAGE(1), .DOUT_WIDTH(16)) u1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[1]), .din0(din0), .din1(din1),
    .in_signed(in_signed), .in_acc(in_acc), .in_tag(in_tag), .out_valid(ov[1]), .out_ready(1'b1),
    .dout(d1), .out_tag(ot[1]));
  aximm_test0_mul_pipe_vr #(.NUM_STAGE(4), .DOUT_WIDTH(64)) u2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[2]), .din0(din0), .din1(din1),
    .in_signed(in_signed), .in_acc(in_acc), .in_tag(in_tag), .out_valid(ov[2]), .out_ready(1'b1),
    .dout(d2), .out_tag(ot[2]));
  aximm_test0_mul_pipe_vr #(.NUM_STAGE(8), .DOUT_WIDTH(64)) u3 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[3]), .din0(din0), .din1(din1),
    .in_signed(in_signed), .in_acc(in_acc), .in_tag(in_tag), .out_valid(ov[3]), .out_ready(1'b1),
    .dout(d3), .out_tag(ot[3]));

  assign od[0] = {4'd0, d0};
  assign od[1] = {48'd0, d1};
  assign od[2] = d2;
  assign od[3] = d3;

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [27:0] y, input logic s, input int w);
    logic [63:0] xe, ye, p;
    xe = s ? {{32{x[31]}}, x} : {32'd0, x};
    ye = s ? {{36{y[27]}}, y} : {36'd0, y};
    p = xe * ye;
    return w >= 64 ? p : p & ((64'd1 << w) - 1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, then check outputs and record accepted beats
  task automatic cyc(input logic iv, input logic ordy, input logic [31:0] x, input logic [27:0] y,
                     input logic s, input logic ac, input logic [3:0] t, input bit xu, input logic [63:0] xe);
    ent_t e;
    int idx;
    @(negedge clk);
    in_valid = iv; out_ready = ordy; din0 = x; din1 = y; in_signed = s; in_acc = ac; in_tag = t;
    #1;
    cycle++;
    if (prev_stall && ov[0]) begin
      chk("stall_dout", od[0], prev_d);
      chk("stall_tag", 64'(ot[0]), 64'(prev_t));
    end
    prev_stall = ov[0] && !out_ready;
    prev_d = od[0];
    prev_t = ot[0];
    for (int k = 0; k < 4; k++)
      if (ov[k] && (k != 0 || out_ready)) begin
        idx = -1;
        for (int i = 0; i < sb.size(); i++) if (idx < 0 && sb[i].k == k) idx = i;
        chk($sformatf("k%0d_expected_beat", k), 64'(idx >= 0), 64'd1);
        if (idx >= 0) begin
          chk($sformatf("k%0d_dout", k), od[k], sb[idx].d);
          chk($sformatf("k%0d_tag", k), 64'(ot[k]), 64'(sb[idx].t));
          if (sb[idx].lat) chk($sformatf("k%0d_latency", k), 64'(cycle - sb[idx].c), 64'(ns[k]));
          sb.delete(idx);
        end
      end
    m_acc = in_valid && ir[0];
    for (int k = 0; k < 4; k++)
      if (in_valid && ir[k]) begin
        e.k = k; e.t = in_tag; e.c = cycle; e.lat = (k != 0) || free;
        if (k == 0) begin
          macc = in_acc ? (macc + ref_mul(din0, din1, in_signed, 60)) & M60 : ref_mul(din0, din1, in_signed, 60);
          e.d = xu ? xe : macc;
        end else e.d = ref_mul(din0, din1, in_signed, dw[k]);
        sb.push_back(e);
      end
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && sb.size() > 0; n++) cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("drain_empty", 64'(sb.size()), 0);
  endtask

  task automatic release_rst();
    @(negedge clk);
    reset_n = 1; in_valid = 0; out_ready = 1;
    #1;
    for (int k = 0; k < 4; k++) chk($sformatf("rel_ready%0d", k), 64'(ir[k]), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 0; in_valid = 0; out_ready = 0; din0 = 0; din1 = 0; in_signed = 0; in_acc = 0; in_tag = 0;
    macc = 0; free = 0; prev_stall = 0; prev_d = 0; prev_t = 0; m_acc = 0;
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_valid%0d", k), 64'(ov[k]), 0);
      chk($sformatf("rst_dout%0d", k), od[k], 0);
      chk($sformatf("rst_tag%0d", k), 64'(ot[k]), 0);
      chk($sformatf("rst_ready%0d", k), 64'(ir[k]), 0);
    end
    release_rst();
    free = 1;
    // unsigned max, then signed -1*3, then the same operands unsigned, back to back
    cyc(1, 1, 32'hFFFFFFFF, 28'hFFFFFFF, 0, 0, 1, 1, 64'h0FFFFFFEF0000001);
    cyc(1, 1, 32'hFFFFFFFF, 28'h0000003, 1, 0, 2, 1, 64'h0FFFFFFFFFFFFFFD);
    cyc(1, 1, 32'hFFFFFFFF, 28'h0000003, 0, 0, 3, 1, 64'h00000002FFFFFFFD);
    cyc(1, 1, 32'h80000000, 28'h8000000, 1, 0, 4, 1, 64'h0400000000000000);
    drain();
    // accumulate chain
    cyc(1, 1, 2, 3, 0, 0, 5, 1, 6);
    cyc(1, 1, 4, 5, 0, 1, 6, 1, 26);
    cyc(1, 1, 1, 1, 0, 1, 7, 1, 27);
    cyc(1, 1, 7, 1, 0, 0, 8, 1, 7);
    drain();
    // random operands and modes through all instances
    for (int n = 0; n < 40; n++)
      cyc(1, 1, $urandom, 28'($urandom), 1'($urandom_range(0, 1)), 0, 4'(n), 0, 0);
    drain();
    // backpressure: two beats fill the stalled two-stage pipe, then random handshakes
    free = 0;
    cyc(1, 0, $urandom, 28'($urandom), 1, 0, 0, 0, 0);
    chk("bp_accept0", 64'(m_acc), 1);
    cyc(1, 0, $urandom, 28'($urandom), 0, 0, 1, 0, 0);
    chk("bp_accept1", 64'(m_acc), 1);
    cyc(1, 0, $urandom, 28'($urandom), 1, 0, 2, 0, 0);
    chk("bp_full_ready", 64'(ir[0]), 0);
    cyc(1, 0, $urandom, 28'($urandom), 1, 0, 2, 0, 0);
    chk("bp_full_accept", 64'(m_acc), 0);
    tg = 2;
    for (int n = 0; n < 400 && tg != 0; n++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 28'($urandom),
          1'($urandom_range(0, 1)), 0, tg, 0, 0);
      if (m_acc) tg = tg + 1;
    end
    chk("bp_all_sent", 64'(tg), 0);
    drain();
    free = 1;
    // reset with accumulator at 26 and two beats in flight
    cyc(1, 1, 2, 3, 0, 0, 1, 1, 6);
    cyc(1, 1, 4, 5, 0, 1, 2, 1, 26);
    drain();
    cyc(1, 1, 1, 1, 0, 1, 3, 0, 0);
    cyc(1, 1, 2, 2, 0, 1, 4, 0, 0);
    @(negedge clk);
    #1;
    chk("inflight_valid", 64'(ov[0]), 1);
    reset_n = 0;
    #1;
    chk("async_rst_valid", 64'(ov[0]), 0);
    chk("async_rst_dout", od[0], 0);
    chk("async_rst_ready", 64'(ir[0]), 0);
    sb.delete();
    macc = 0;
    prev_stall = 0;
    release_rst();
    for (int n = 0; n < 10; n++) begin
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
      chk("no_stale", 64'(ov[0] | ov[1] | ov[2] | ov[3]), 0);
    end
    cyc(1, 1, 3, 3, 0, 1, 9, 1, 9);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/aximm_test0_mul_pipe_vr.md
Name: aximm_test0_mul_pipe_vr

Overview:
Parametrised, fully pipelined integer multiplier with a valid/ready stream interface. It has a configurable stage count and a per-beat signed/unsigned mode. An optional multiply-accumulate mode and a sideband tag travel with each beat. It sits between HLS-generated datapath logic and AXI-MM address/length computation, replacing the fixed 2-stage clock-enable multipliers where backpressure or a MAC is needed.

Parameters:
DIN0_WIDTH, 32, width of operand din0
DIN1_WIDTH, 28, width of operand din1
DOUT_WIDTH, 60, result width; result is truncated or extended to this width
NUM_STAGE, 2, pipeline depth in registers, legal range 1..8
ACC_EN, 0, 1 enables the accumulate path; 0 means in_acc is ignored
TAG_WIDTH, 4, width of the sideband tag carried alongside each beat

Ports:
clk  in  1  clock; all logic is rising-edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat this cycle
din0  in  DIN0_WIDTH  operand A
din1  in  DIN1_WIDTH  operand B
in_signed  in  1  1 = both operands two's complement; 0 = both unsigned
in_acc  in  1  1 = add the product to the accumulator (only when ACC_EN=1)
in_tag  in  TAG_WIDTH  sideband tag, returned unchanged with the result
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts the result
dout  out  DOUT_WIDTH  product or accumulated sum
out_tag  out  TAG_WIDTH  tag of the beat currently on dout

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- While reset_n=0:
  - all stage valid bits, out_valid, dout, out_tag and the accumulator are 0;
  - in_ready=0.
- The first cycle after reset_n is released has in_ready=1.
- Pipeline control:
  - advance = !valid[NUM_STAGE-1] || out_ready.
  - in_ready = advance (combinational; reset forces it low).
  - A beat is accepted when in_valid && in_ready.
  - On advance, every stage shifts by one. Bubbles shift too; there is no bubble collapsing.
  - When advance=0, all stages hold their contents.
- Latency and throughput:
  - With out_ready held 1, a beat accepted in cycle t has out_valid=1 in cycle t+NUM_STAGE.
  - Throughput is 1 beat per cycle.
  - Beat order is strictly preserved. No beat is lost or duplicated under any out_ready pattern.
- Output stability: while out_valid=1 and out_ready=0, dout and out_tag hold stable.
- Arithmetic:
  - Each operand is extended by 1 bit: sign-extended if in_signed=1, zero-extended otherwise.
  - The full-precision signed product (DIN0_WIDTH+DIN1_WIDTH+2 bits) is formed.
  - That product is truncated to its low DOUT_WIDTH bits, or sign-extended if DOUT_WIDTH is larger.
  - in_signed is sampled per beat and carried down the pipe. Mixed-mode beats back to back are legal.
  - The multiplier may be split across any stages, but the result must be bit-exact to the rule above.
- Accumulate (ACC_EN=1):
  - in_acc travels with the beat.
  - When the beat enters the final stage: result = in_acc ? acc + product : product, computed modulo 2^DOUT_WIDTH, and acc <= result.
  - A beat with in_acc=0 therefore restarts the sum.
  - acc updates only on an actual final-stage load, never while the pipe is stalled.
- Accumulate disabled (ACC_EN=0): no accumulator register is present and result = product.
- Tags: in_tag is carried verbatim. out_tag aligns with dout.
- Simultaneous accept and emit in one cycle is legal and must neither drop nor duplicate a beat.
- Reset mid-operation:
  - all in-flight beats are discarded and acc clears;
  - no stale beat appears after release.

Test Plan:
1. Unsigned maximum values: din0=0xFFFFFFFF, din1=0xFFFFFFF, in_signed=0, out_ready=1 -> dout=0xFFFFFFEF0000001, out_valid exactly 2 cycles after acceptance.
2. Signed: din0=0xFFFFFFFF (-1), din1=0x0000003, in_signed=1 -> dout=0xFFFFFFFFFFFFFFD (-3). Back to back with beat 1, each beat keeps its own mode.
3. Accumulate with ACC_EN=1:
   - beats (2,3,acc=0), (4,5,acc=1), (1,1,acc=1), (7,1,acc=0);
   - dout sequence must be 6, 26, 27, 7.
4. Backpressure:
   - stream tags 0..15 with random in_valid and random out_ready;
   - with NUM_STAGE=2 and out_ready=0, in_ready must drop after 2 beats are held;
   - output tags must be 0..15 in order with no loss or duplication;
   - dout must stay stable while stalled.
5. Reset mid-stream: drive reset_n=0 with 2 beats in flight and acc=26 -> out_valid=0 immediately (asynchronous). After release:
   - in_ready=1;
   - no stale output appears;
   - the next in_acc=1 beat 3x3 yields 9.
6. Parameter sweep: NUM_STAGE in {1,4,8} and DOUT_WIDTH in {16,64} with random signed/unsigned operands, checked against a reference model -> latency equals NUM_STAGE and results are bit-exact.
